logic_capture: RTL
==================

Name: logic_capture

Overview:
- Consumer of the prescaler's `ce` strobe: the sampling and trigger core of the logic analyzer.
- Synchronizes the probe inputs and takes one sample per `ce` pulse.
- Records a pre-trigger window, detects a masked pattern trigger, then records post-trigger samples.
- Writes every sample into a circular sample RAM through a simple write port.

Parameters:
- WIDTH, 8, number of probe channels (bits per sample).
- DEPTH_LOG2, 10, log2 of sample RAM depth; DEPTH = 2**DEPTH_LOG2 samples per capture.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, asynchronous, active-high.
- ce  input  1  sample strobe from prescaler; one sample per clk edge where ce=1.
- probes  input  WIDTH  raw asynchronous probe lines.
- arm  input  1  single-cycle start request.
- abort  input  1  single-cycle cancel request.
- trig_mask  input  WIDTH  1 = channel participates in trigger.
- trig_value  input  WIDTH  required level for masked channels.
- pretrig_len  input  DEPTH_LOG2  number of pre-trigger samples; latched on accepted arm.
- mem_we  output  1  sample RAM write enable, one-cycle pulse.
- mem_addr  output  DEPTH_LOG2  RAM write address.
- mem_wdata  output  WIDTH  sample data.
- busy  output  1  high while in PRE, WAIT_TRIG or POST.
- triggered  output  1  set when the trigger sample is taken; cleared on arm or abort.
- done  output  1  capture complete; held until next arm or reset.
- start_addr  output  DEPTH_LOG2  address of the oldest sample in the finished capture.

Behaviour:
- Reset (async, rst=1): state=IDLE.
  - All outputs are 0.
  - Synchronizer flops, address and counters are 0.
- Probe synchronizer: 2-flop chain clocked every clk, independent of ce; `s2` is the synchronized value.
- Sample event: clk edge where ce=1 and state is PRE, WAIT_TRIG or POST.
  - On the next cycle: mem_we=1, mem_wdata = s2 as of that edge, mem_addr = current write pointer.
  - Write pointer then increments, wrapping modulo DEPTH.
  - Outside sample events mem_we=0; mem_addr and mem_wdata hold their last value.
- Trigger match: (s2 & trig_mask) == (trig_value & trig_mask).
  - trig_mask=0 matches on the first sample evaluated.
- State IDLE / DONE:
  - arm=1 latches pretrig_len, pointer=0, clears done and triggered.
  - Next state is PRE if pretrig_len>0, else WAIT_TRIG.
- State PRE:
  - Each sample increments pre_cnt.
  - After pretrig_len samples -> WAIT_TRIG.
  - Trigger is not evaluated in PRE, so the full pre-trigger window is guaranteed.
- State WAIT_TRIG:
  - Every sample is written (circular overwrite).
  - On a matching sample: the sample is written, triggered=1, trig_addr = its address.
  - post_cnt = 1, next state POST.
  - The trigger sample counts as the first post-trigger sample.
- State POST:
  - Sampling continues until post_cnt reaches DEPTH - pretrig_len.
  - The last write's mem_we pulse coincides with the transition to DONE.
  - In DONE: done=1, busy=0, start_addr = (trig_addr - pretrig_len) mod DEPTH.
- Edge cases:
  - arm while busy: ignored.
  - abort in any state: -> IDLE next cycle, busy=0, triggered=0, done=0, no further mem_we (an already-registered pulse may complete in that cycle).
  - abort and arm in the same cycle: abort wins.
  - ce held high continuously: one sample per clk.
  - ce=0 indefinitely: state frozen, no writes.
- Widths: counters are DEPTH_LOG2+1 bits so that DEPTH itself is representable; address arithmetic is unsigned modulo DEPTH.

Decomposition:
- Package `logic_capture_pkg`:
  - state enum (IDLE, PRE, WAIT_TRIG, POST, DONE)
  - default WIDTH and DEPTH_LOG2 constants
  - a trig_match function.
- Sub-module `probe_sync`: parameterized WIDTH-bit 2-flop synchronizer with async reset.

Test Plan (WIDTH=8, DEPTH_LOG2=4, DEPTH=16):
1. Reset: assert rst mid-capture with ce toggling -> all outputs 0 immediately (asynchronous); no mem_we until the next arm.
2. trig_mask=0x00, pretrig_len=0, ce=1 constant, arm -> triggered on the first sample; 16 writes to addr 0..15 with data = probes delayed 2+1 cycles; then done=1, start_addr=0.
3. pretrig_len=4, mask=0x01, value=0x01, probes=0x00 for 10 samples then 0x01 -> writes addr 0..9, trigger at addr 10, 12 post writes ending at addr 5; then done=1, start_addr=6, 22 writes total.
4. ce pulsing every 3rd cycle -> exactly one mem_we per ce, one cycle after it; addresses consecutive; no writes between ce pulses.
5. abort during POST -> busy=0 and triggered=0 next cycle; done stays 0; mem_we silent afterwards; a new arm restarts at addr 0.
6. arm during WAIT_TRIG -> ignored, no pointer reset; arm while done=1 -> done clears next cycle and capture restarts with the newly latched pretrig_len.

Source files
------------

// File: rtl/logic_capture_pkg.sv
// ---------------------------------------------------------------------------
// logic_capture_pkg
// Shared definitions for the logic analyzer capture core:
//   - state_t        : capture FSM states
//   - DEF_WIDTH      : default number of probe channels
//   - DEF_DEPTH_LOG2 : default log2 of sample RAM depth
//   - trig_match()   : masked pattern compare used by the trigger
// ---------------------------------------------------------------------------
package logic_capture_pkg;

   localparam int DEF_WIDTH      = 8;
   localparam int DEF_DEPTH_LOG2 = 10;

   // trig_match works on vectors zero-extended to this width, so it
   // supports any probe width up to TRIG_MAX_W channels.
   localparam int TRIG_MAX_W     = 64;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRE       = 3'd1,
      WAIT_TRIG = 3'd2,
      POST      = 3'd3,
      DONE      = 3'd4
   } state_t;

   // True when every channel selected by mask sits at the level given
   // by value. An all-zero mask always matches.
   function automatic logic trig_match(input logic [TRIG_MAX_W-1:0] s,
                                       input logic [TRIG_MAX_W-1:0] mask,
                                       input logic [TRIG_MAX_W-1:0] value);
      return (((s ^ value) & mask) == '0);
   endfunction

endpackage

// File: rtl/probe_sync.sv
// ---------------------------------------------------------------------------
// probe_sync
// Two-flop synchronizer for the asynchronous probe lines. Runs on every
// clk edge, independent of the sample strobe.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset, clears both stages
//   d    : raw asynchronous input (WIDTH bits)
//   q    : synchronized output (second flop stage)
// ---------------------------------------------------------------------------
module probe_sync #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] s1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         q  <= '0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/logic_capture.sv
// ---------------------------------------------------------------------------
// logic_capture
// Sampling and trigger core of the logic analyzer. Takes one synchronized
// probe sample per ce pulse, records a pre-trigger window, waits for a
// masked pattern trigger, then records post-trigger samples into a
// circular sample RAM through a simple write port.
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   ce           : sample strobe from the prescaler
//   probes       : raw asynchronous probe lines
//   arm, abort   : single-cycle start / cancel requests (abort wins)
//   trig_mask    : 1 = channel participates in the trigger
//   trig_value   : required level for masked channels
//   pretrig_len  : pre-trigger sample count, latched on an accepted arm
//   mem_we       : one-cycle RAM write strobe
//   mem_addr     : RAM write address
//   mem_wdata    : sample data
//   busy         : high in PRE, WAIT_TRIG and POST
//   triggered    : trigger sample has been taken
//   done         : capture complete, held until the next arm or reset
//   start_addr   : address of the oldest sample of the finished capture
// Handshake: arm and abort are level-sampled single-cycle requests with no
// ready; arm is only accepted in IDLE or DONE, abort is always accepted.
// mem_we is a fire-and-forget write strobe with no backpressure.
// ---------------------------------------------------------------------------
module logic_capture
   import logic_capture_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic [WIDTH-1:0]      probes,
   input  logic                  arm,
   input  logic                  abort,
   input  logic [WIDTH-1:0]      trig_mask,
   input  logic [WIDTH-1:0]      trig_value,
   input  logic [DEPTH_LOG2-1:0] pretrig_len,
   output logic                  mem_we,
   output logic [DEPTH_LOG2-1:0] mem_addr,
   output logic [WIDTH-1:0]      mem_wdata,
   output logic                  busy,
   output logic                  triggered,
   output logic                  done,
   output logic [DEPTH_LOG2-1:0] start_addr
);

   // Counters carry one extra bit so that DEPTH itself is representable.
   localparam int CW = DEPTH_LOG2 + 1;
   localparam logic [CW-1:0] DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};

   state_t                state;
   logic [WIDTH-1:0]      s2;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] plen;
   logic [DEPTH_LOG2-1:0] trig_addr;
   logic [CW-1:0]         pre_cnt;
   logic [CW-1:0]         post_cnt;

   logic                  sample;
   logic                  hit;
   logic [CW-1:0]         post_target;
   logic [CW-1:0]         pre_next;
   logic [CW-1:0]         post_next;

   probe_sync #(.WIDTH(WIDTH)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (probes),
      .q   (s2)
   );

   assign sample      = ce && ((state == PRE) || (state == WAIT_TRIG) || (state == POST));
   assign hit         = trig_match(TRIG_MAX_W'(s2), TRIG_MAX_W'(trig_mask), TRIG_MAX_W'(trig_value));
   // Post-trigger length includes the trigger sample itself, so pre + post
   // always fills the RAM exactly once.
   assign post_target = DEPTH_C - {1'b0, plen};
   assign pre_next    = pre_cnt + 1'b1;
   assign post_next   = post_cnt + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         plen       <= '0;
         trig_addr  <= '0;
         pre_cnt    <= '0;
         post_cnt   <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
         triggered  <= 1'b0;
         done       <= 1'b0;
         start_addr <= '0;
      end else begin
         mem_we <= 1'b0;
         if (abort) begin
            // A write registered on the previous edge still completes;
            // nothing new is issued from here on.
            state     <= IDLE;
            busy      <= 1'b0;
            triggered <= 1'b0;
            done      <= 1'b0;
         end else begin
            if (sample) begin
               mem_we    <= 1'b1;
               mem_addr  <= wr_ptr;
               mem_wdata <= s2;
               wr_ptr    <= wr_ptr + 1'b1;
            end
            case (state)
               IDLE, DONE: begin
                  if (arm) begin
                     plen      <= pretrig_len;
                     wr_ptr    <= '0;
                     pre_cnt   <= '0;
                     post_cnt  <= '0;
                     done      <= 1'b0;
                     triggered <= 1'b0;
                     busy      <= 1'b1;
                     state     <= (pretrig_len != '0) ? PRE : WAIT_TRIG;
                  end
               end
               PRE: begin
                  // Trigger is deliberately ignored here so the pre-trigger
                  // window is always fully populated.
                  if (ce) begin
                     pre_cnt <= pre_next;
                     if (pre_next == {1'b0, plen}) begin
                        state <= WAIT_TRIG;
                     end
                  end
               end
               WAIT_TRIG: begin
                  if (ce && hit) begin
                     triggered <= 1'b1;
                     trig_addr <= wr_ptr;
                     post_cnt  <= CW'(1);
                     if (post_target == CW'(1)) begin
                        // Pre-trigger window fills all but one slot: the
                        // trigger sample alone completes the capture.
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        start_addr <= wr_ptr - plen;
                     end else begin
                        state <= POST;
                     end
                  end
               end
               POST: begin
                  if (ce) begin
                     post_cnt <= post_next;
                     if (post_next == post_target) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        start_addr <= trig_addr - plen;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
